// File: rtl/tsc_capture.sv
// tsc_capture: transient signal capture.
// Samples a handshaked ADC into a DEPTH-entry ring buffer. A strict
// unsigned crossing of `thresh` marks the trigger sample. POST more samples
// are taken, the frame is frozen (`cd`), and on `sbf` it is shifted out
// serially on `sd`/`sd_valid`, oldest sample first, MSB first.
//
// Optional build macro: TSC_TIMESTAMP_EN. When defined, the serial frame is
// preceded by the TS_W-bit trigger timestamp, MSB first.
//
// ADC handshake: `adc_req` is a one-cycle pulse. After a request the block
// waits, and the first cycle with `adc_rdy`=1 transfers `adc_dat`. The next
// request (if any) is raised on the cycle right after that transfer.
// `adc_rdy` while no request is outstanding is ignored.
module tsc_capture #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int POST   = 8,
  parameter int TS_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sbf,
  input  logic [DATA_W-1:0] thresh,
  output logic              adc_req,
  input  logic              adc_rdy,
  input  logic [DATA_W-1:0] adc_dat,
  output logic              adc_rst,
  output logic              cd,
  output logic              trd,
  output logic [TS_W-1:0]   trig_ts,
  output logic              sd,
  output logic              sd_valid
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PRE = DEPTH - POST - 1;
`ifdef TSC_TIMESTAMP_EN
  localparam int HDR_BITS = TS_W;
`else
  localparam int HDR_BITS = 0;
`endif
  localparam int FRAME_BITS = HDR_BITS + DEPTH * DATA_W;
  localparam int BW  = $clog2(FRAME_BITS + 1);
  localparam int BPW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_POST,
    S_DONE,
    S_SEND
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     head;
  logic [AW-1:0]     cnt;
  logic              waiting;
  logic [TS_W-1:0]   timer;
  logic [AW-1:0]     rd_ptr;
  logic [BPW-1:0]    bit_pos;
  logic [BW-1:0]     bit_cnt;
  logic              sampling;
  logic              wr_en;
  logic              shift;
  logic              cur_bit;
`ifdef TSC_TIMESTAMP_EN
  localparam int TPW = (TS_W > 1) ? $clog2(TS_W) : 1;
  logic              in_hdr;
  logic [TPW-1:0]    hdr_pos;
`endif

  assign sampling = (state == S_ARM) || (state == S_RUN) || (state == S_POST);
  // A sample is accepted only while a request is outstanding.
  assign wr_en    = sampling && waiting && adc_rdy;
  // One frame bit leaves per cycle from the sbf cycle until the frame ends.
  assign shift    = ((state == S_DONE) && sbf) ||
                    ((state == S_SEND) && (bit_cnt != BW'(FRAME_BITS)));

  // Select the next frame bit: header bits first (if built in), then samples.
  always_comb begin
    cur_bit = mem[rd_ptr][bit_pos];
`ifdef TSC_TIMESTAMP_EN
    if (in_hdr) cur_bit = trig_ts[hdr_pos];
`endif
  end

  // Ring buffer storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[head] <= adc_dat;
  end

  // Free-running timestamp counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) timer <= '0;
    else       timer <= timer + 1'b1;
  end

  // Capture/send FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      head     <= '0;
      cnt      <= '0;
      waiting  <= 1'b0;
      adc_req  <= 1'b0;
      adc_rst  <= 1'b1;
      cd       <= 1'b0;
      trd      <= 1'b0;
      trig_ts  <= '0;
      sd       <= 1'b0;
      sd_valid <= 1'b0;
      rd_ptr   <= '0;
      bit_pos  <= '0;
      bit_cnt  <= '0;
`ifdef TSC_TIMESTAMP_EN
      in_hdr   <= 1'b0;
      hdr_pos  <= '0;
`endif
    end else begin
      adc_req <= 1'b0;
      adc_rst <= 1'b0;

      // The sample write always completes, whatever the state decision is.
      if (wr_en) head <= head + 1'b1;

      case (state)
        S_IDLE: begin
          cd  <= 1'b0;
          trd <= 1'b0;
          if (start) begin
            adc_rst <= 1'b1;
            head    <= '0;
            cnt     <= '0;
            waiting <= 1'b0;
            state   <= S_ARM;
          end
        end

        S_ARM: begin
          if (!waiting) begin
            // First request of a capture, one cycle after the adc_rst pulse.
            adc_req <= 1'b1;
            waiting <= 1'b1;
          end else if (adc_rdy) begin
            adc_req <= 1'b1;
            if (cnt == AW'(PRE - 1)) begin
              cnt   <= '0;
              state <= S_RUN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        S_RUN: begin
          if (wr_en) begin
            adc_req <= 1'b1;
            if (adc_dat > thresh) begin
              trd     <= 1'b1;
              trig_ts <= timer;
              cnt     <= '0;
              state   <= S_POST;
            end
          end
        end

        S_POST: begin
          if (wr_en) begin
            if (cnt == AW'(POST - 1)) begin
              // Last sample: no further request; point the reader at the
              // slot after this write, which is the oldest sample.
              waiting <= 1'b0;
              cd      <= 1'b1;
              state   <= S_DONE;
              rd_ptr  <= head + 1'b1;
              bit_pos <= BPW'(DATA_W - 1);
              bit_cnt <= '0;
`ifdef TSC_TIMESTAMP_EN
              in_hdr  <= 1'b1;
              hdr_pos <= TPW'(TS_W - 1);
`endif
            end else begin
              cnt     <= cnt + 1'b1;
              adc_req <= 1'b1;
            end
          end
        end

        S_DONE: begin
          if (sbf) begin
            sd_valid <= 1'b1;
            state    <= S_SEND;
          end
        end

        S_SEND: begin
          if (bit_cnt == BW'(FRAME_BITS)) begin
            sd       <= 1'b0;
            sd_valid <= 1'b0;
            cd       <= 1'b0;
            trd      <= 1'b0;
            state    <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase

      // Serialiser: emit the selected bit and step to the following one.
      if (shift) begin
        sd      <= cur_bit;
        bit_cnt <= bit_cnt + 1'b1;
`ifdef TSC_TIMESTAMP_EN
        if (in_hdr) begin
          if (hdr_pos == '0) in_hdr <= 1'b0;
          else               hdr_pos <= hdr_pos - 1'b1;
        end else
`endif
        if (bit_pos == '0) begin
          bit_pos <= BPW'(DATA_W - 1);
          rd_ptr  <= rd_ptr + 1'b1;
        end else begin
          bit_pos <= bit_pos - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tsc_capture.sv
// tb_tsc_capture: directed bench for tsc_capture (DATA_W=8, DEPTH=8, POST=3).
// Stimulus pushes expected serial frames into queues; a negedge monitor
// reassembles sd/sd_valid and pops/compares independently.
module tb_tsc_capture;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int POST   = 3;
  localparam int TS_W   = 32;
`ifdef TSC_TIMESTAMP_EN
  localparam int HDR = TS_W;
`else
  localparam int HDR = 0;
`endif
  localparam int FRAME = HDR + DEPTH * DATA_W;

  logic              clk;
  logic              reset;
  logic              start;
  logic              sbf;
  logic [DATA_W-1:0] thresh;
  logic              adc_req;
  logic              adc_rdy;
  logic [DATA_W-1:0] adc_dat;
  logic              adc_rst;
  logic              cd;
  logic              trd;
  logic [TS_W-1:0]   trig_ts;
  logic              sd;
  logic              sd_valid;

  logic [DATA_W-1:0] exp_q[$];
  int                len_q[$];
  logic [TS_W-1:0]   ts_q[$];
  logic [DATA_W-1:0] exp_frame [DEPTH];
  logic [TS_W-1:0]   tb_timer;

  int errors = 0;
  int checks = 0;

  tsc_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .POST(POST), .TS_W(TS_W)) dut (
    .clk(clk), .reset(reset), .start(start), .sbf(sbf), .thresh(thresh),
    .adc_req(adc_req), .adc_rdy(adc_rdy), .adc_dat(adc_dat), .adc_rst(adc_rst),
    .cd(cd), .trd(trd), .trig_ts(trig_ts), .sd(sd), .sd_valid(sd_valid)
  );

  // Clock and reference timer (cleared by reset, +1 per clock).
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) tb_timer <= '0;
    else       tb_timer <= tb_timer + 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: wait for a request, optionally delay, then present one sample.
  task automatic feed(input logic [DATA_W-1:0] v, input int dly, output logic [TS_W-1:0] ts);
    int n;
    n = 0;
    while (adc_req !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("adc_req_timeout", {63'd0, adc_req}, 64'd1);
    repeat (dly) tick();
    tick();
    adc_rdy = 1'b1;
    adc_dat = v;
    ts      = tb_timer;
    tick();
    adc_rdy = 1'b0;
  endtask

  task automatic do_start(input bit spur);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("adc_rst_pulse", {63'd0, adc_rst}, 64'd1);
    check("adc_req_in_rst_cycle", {63'd0, adc_req}, 64'd0);
    if (spur) begin
      adc_rdy = 1'b1;
      adc_dat = 8'hEE;
    end
    tick();
    adc_rdy = 1'b0;
    check("adc_req_first", {63'd0, adc_req}, 64'd1);
    check("adc_rst_clear", {63'd0, adc_rst}, 64'd0);
  endtask

  // Standard capture: 0x10..0x17, trigger 0x90, then 0x20..0x22.
  task automatic capture_std(input int dly, input bit spur, output logic [TS_W-1:0] ts);
    logic [TS_W-1:0] t;
    int reqs;
    do_start(spur);
    for (int i = 0; i < 8; i++) feed(8'(8'h10 + i), dly, t);
    check("trd_before_trigger", {63'd0, trd}, 64'd0);
    feed(8'h90, dly, ts);
    check("trd_after_trigger", {63'd0, trd}, 64'd1);
    check("trig_ts", {32'd0, trig_ts}, {32'd0, ts});
    feed(8'h20, dly, t);
    feed(8'h21, dly, t);
    check("cd_before_last_post", {63'd0, cd}, 64'd0);
    feed(8'h22, dly, t);
    check("cd_after_post", {63'd0, cd}, 64'd1);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      if (spur) begin
        adc_rdy = i[0];
        adc_dat = 8'hEE;
      end
      tick();
      reqs += int'(adc_req);
    end
    adc_rdy = 1'b0;
    check("no_req_after_done", 64'(reqs), 64'd0);
    check("cd_held_in_done", {63'd0, cd}, 64'd1);
    exp_frame = '{8'h14, 8'h15, 8'h16, 8'h17, 8'h90, 8'h20, 8'h21, 8'h22};
  endtask

  task automatic push_frame(input logic [TS_W-1:0] ts);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(exp_frame[i]);
    len_q.push_back(FRAME);
    ts_q.push_back(ts);
  endtask

  task automatic send_and_wait(input logic [TS_W-1:0] ts);
    int n;
    push_frame(ts);
    sbf = 1'b1;
    tick();
    sbf = 1'b0;
    check("sd_valid_first", {63'd0, sd_valid}, 64'd1);
    n = 0;
    while (sd_valid && n < FRAME + 50) begin
      tick();
      n++;
    end
    if (n >= FRAME + 50) check("send_timeout", {63'd0, sd_valid}, 64'd0);
    tick();
    check("cd_after_send", {63'd0, cd}, 64'd0);
    check("trd_after_send", {63'd0, trd}, 64'd0);
  endtask

  // Monitor / scoreboard: reassemble frame bits and compare against queues.
  int              run_len = 0;
  int              fbits   = 0;
  bit              in_run  = 1'b0;
  logic [7:0]      acc_b;
  logic [TS_W-1:0] acc_ts;
  always @(negedge clk) begin
    if (reset) begin
      run_len = 0;
      fbits   = 0;
      in_run  = 1'b0;
    end else if (sd_valid) begin
      in_run = 1'b1;
      run_len++;
`ifdef TSC_TIMESTAMP_EN
      if (fbits < TS_W) begin
        acc_ts = {acc_ts[TS_W-2:0], sd};
        if (fbits == TS_W - 1) begin
          if (ts_q.size() == 0) check("unexpected_ts", {32'd0, acc_ts}, 64'hDEAD);
          else check("frame_ts", {32'd0, acc_ts}, {32'd0, ts_q.pop_front()});
        end
      end else begin
`else
      begin
`endif
        acc_b = {acc_b[6:0], sd};
        if (((fbits - HDR) % 8) == 7) begin
          if (exp_q.size() == 0) check("unexpected_sample", {56'd0, acc_b}, 64'hDEAD);
          else check("frame_sample", {56'd0, acc_b}, {56'd0, exp_q.pop_front()});
        end
      end
      fbits++;
    end else if (in_run) begin
      if (len_q.size() == 0) check("unexpected_frame", 64'(run_len), 64'd0);
      else check("sd_valid_len", 64'(run_len), 64'(len_q.pop_front()));
      check("cd_drop_with_valid", {63'd0, cd}, 64'd0);
      in_run  = 1'b0;
      run_len = 0;
      fbits   = 0;
    end
  end

  // Directed test sequence.
  initial begin
    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] t;
    int n;
    reset   = 1'b1;
    start   = 1'b0;
    sbf     = 1'b0;
    thresh  = 8'h80;
    adc_rdy = 1'b0;
    adc_dat = '0;
    repeat (3) tick();
    check("rst_adc_rst", {63'd0, adc_rst}, 64'd1);
    check("rst_cd", {63'd0, cd}, 64'd0);
    check("rst_trd", {63'd0, trd}, 64'd0);
    check("rst_sd_valid", {63'd0, sd_valid}, 64'd0);
    check("rst_adc_req", {63'd0, adc_req}, 64'd0);
    check("rst_trig_ts", {32'd0, trig_ts}, 64'd0);
    reset = 1'b0;
    tick();
    check("adc_rst_after_release", {63'd0, adc_rst}, 64'd0);

    // Zero-delay ADC, basic capture and send.
    capture_std(0, 1'b0, ts);
    send_and_wait(ts);
    check("trig_ts_held", {32'd0, trig_ts}, {32'd0, ts});

    // Threshold boundaries: ARM ignores big values, 0x80 does not trigger.
    do_start(1'b0);
    feed(8'hFF, 0, t); check("arm_no_trig_ff", {63'd0, trd}, 64'd0);
    feed(8'h81, 0, t); check("arm_no_trig_81", {63'd0, trd}, 64'd0);
    feed(8'h90, 0, t);
    feed(8'hA0, 0, t); check("arm_no_trig_a0", {63'd0, trd}, 64'd0);
    feed(8'h80, 0, t); check("equal_no_trig", {63'd0, trd}, 64'd0);
    feed(8'h81, 0, ts); check("trig_81", {63'd0, trd}, 64'd1);
    check("trig_ts_81", {32'd0, trig_ts}, {32'd0, ts});
    feed(8'h01, 0, t);
    feed(8'h02, 0, t);
    feed(8'h03, 0, t);
    check("cd_thresh_case", {63'd0, cd}, 64'd1);
    exp_frame = '{8'h81, 8'h90, 8'hA0, 8'h80, 8'h81, 8'h01, 8'h02, 8'h03};
    send_and_wait(ts);

    // Slow ADC plus spurious strobes in IDLE, the adc_rst cycle and DONE.
    adc_rdy = 1'b1;
    adc_dat = 8'hEE;
    tick();
    tick();
    adc_rdy = 1'b0;
    capture_std(5, 1'b1, ts);
    send_and_wait(ts);

    // Reset in the middle of SEND.
    capture_std(0, 1'b0, ts);
    push_frame(ts);
    sbf = 1'b1;
    tick();
    sbf = 1'b0;
    n = 0;
    while (sd_valid && n < 20) begin
      tick();
      n++;
    end
    check("mid_send_reached", 64'(n), 64'd20);
    reset = 1'b1;
    #1;
    check("rst_mid_sd_valid", {63'd0, sd_valid}, 64'd0);
    check("rst_mid_sd", {63'd0, sd}, 64'd0);
    check("rst_mid_cd", {63'd0, cd}, 64'd0);
    check("rst_mid_trd", {63'd0, trd}, 64'd0);
    check("rst_mid_adc_rst", {63'd0, adc_rst}, 64'd1);
    check("rst_mid_trig_ts", {32'd0, trig_ts}, 64'd0);
    exp_q.delete();
    len_q.delete();
    ts_q.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_mid_adc_rst_rel", {63'd0, adc_rst}, 64'd0);
    check("rst_mid_sd_valid_rel", {63'd0, sd_valid}, 64'd0);
    do_start(1'b0);

    repeat (5) tick();
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("len_q_empty", 64'(len_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
